// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: load/store mode codes, FSM states
// and the alignment check used when a request is accepted.
package lsu_pkg;

  typedef enum logic [2:0] {
    LD_LB   = 3'b000,
    LD_LH   = 3'b001,
    LD_LW   = 3'b010,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101,
    LD_NONE = 3'b111
  } load_mode_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } store_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  // size: 00 byte, 01 halfword, 1x word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, and
// load byte/halfword selection with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_mode,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  input  logic [2:0]      ld_mode,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    wdata = '0;
    wstrb = '0;
    case (st_mode)
      ST_SB: begin
        wdata = {(XLEN/8){st_data[7:0]}};
        wstrb = 4'b0001 << st_off;
      end
      ST_SH: begin
        wdata = {(XLEN/16){st_data[15:0]}};
        wstrb = 4'b0011 << st_off;
      end
      ST_SW: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = 8'(rdata >> {ld_off, 3'b000});
    lane_half = 16'(rdata >> {ld_off[1], 4'b0000});
    ld_data   = rdata;
    case (ld_mode)
      LD_LB:   ld_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      LD_LH:   ld_data = {{(XLEN-16){lane_half[15]}}, lane_half};
      LD_LBU:  ld_data = {{(XLEN-8){1'b0}}, lane_byte};
      LD_LHU:  ld_data = {{(XLEN-16){1'b0}}, lane_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one load or store from execute, runs it over a
// request/grant/rvalid bus with timeout, and writes aligned load data back.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mem_load_mode,
  input  logic [XLEN-1:0] mem_load_addr,
  input  logic [4:0]      mem_load_regs_addr,
  input  logic [1:0]      mem_store_mode,
  input  logic [XLEN-1:0] mem_store_addr,
  input  logic [XLEN-1:0] mem_store_data,
  output logic            busy,
  output logic            regs_write_en,
  output logic [4:0]      regs_write_addr,
  output logic [XLEN-1:0] regs_write_data,
  output logic            unpause_signal,
  output logic            error,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state, state_n;
  logic [CW-1:0]   cnt;
  logic            is_load;
  logic [2:0]      ld_mode;
  logic [1:0]      ld_off;
  logic [4:0]      rd;
  logic [XLEN-1:0] ld_data;

  logic            load_req, store_req, accept, acc_bad, bad_req, abort, timed_out;
  logic [1:0]      acc_size;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] st_wdata, ld_ext;
  logic [3:0]      st_wstrb;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_mode (mem_store_mode),
    .st_off  (mem_store_addr[1:0]),
    .st_data (mem_store_data),
    .ld_mode (ld_mode),
    .ld_off  (ld_off),
    .rdata   (bus_rdata),
    .wdata   (st_wdata),
    .wstrb   (st_wstrb),
    .ld_data (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    load_req  = (mem_load_mode != LD_NONE);
    store_req = (mem_store_mode != ST_NONE);
    accept    = (state == S_IDLE) && (load_req || store_req);
    acc_size  = load_req ? mem_load_mode[1:0] : (mem_store_mode - 2'd1);
    acc_addr  = load_req ? mem_load_addr : mem_store_addr;
    acc_bad   = is_misaligned(acc_size, acc_addr[1:0]);
    bad_req   = accept && acc_bad;
    timed_out = (cnt == CW'(TIMEOUT - 1));
    abort     = ((state == S_REQ) && !bus_gnt && timed_out) ||
                ((state == S_WAIT) && !bus_rvalid && timed_out);
    state_n   = state;
    case (state)
      S_IDLE: if (accept && !acc_bad) state_n = S_REQ;
      S_REQ: begin
        if (bus_gnt)        state_n = is_load ? S_WAIT : S_DONE;
        else if (timed_out) state_n = S_IDLE;
      end
      S_WAIT: begin
        if (bus_rvalid)     state_n = S_DONE;
        else if (timed_out) state_n = S_IDLE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // All outputs are registered from the next-state so they line up with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      is_load         <= 1'b0;
      ld_mode         <= LD_NONE;
      ld_off          <= '0;
      rd              <= '0;
      ld_data         <= '0;
      busy            <= 1'b0;
      regs_write_en   <= 1'b0;
      regs_write_addr <= '0;
      regs_write_data <= '0;
      unpause_signal  <= 1'b0;
      error           <= 1'b0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      bus_wstrb       <= '0;
    end else begin
      regs_write_en  <= 1'b0;
      unpause_signal <= 1'b0;
      error          <= 1'b0;
      busy           <= (state_n != S_IDLE);
      bus_req        <= (state_n == S_REQ);

      if (state_n != state)                          cnt <= '0;
      else if (state == S_REQ || state == S_WAIT)    cnt <= cnt + CW'(1);

      if (accept && !acc_bad) begin
        is_load   <= load_req;
        ld_mode   <= mem_load_mode;
        ld_off    <= mem_load_addr[1:0];
        rd        <= mem_load_regs_addr;
        bus_addr  <= {acc_addr[XLEN-1:2], 2'b00};
        bus_we    <= !load_req;
        bus_wdata <= load_req ? '0 : st_wdata;
        bus_wstrb <= load_req ? '0 : st_wstrb;
      end

      if (bad_req || abort) begin
        error          <= 1'b1;
        unpause_signal <= 1'b1;
      end

      if (state == S_WAIT && bus_rvalid) ld_data <= ld_ext;

      if (state == S_DONE) begin
        unpause_signal <= 1'b1;
        if (is_load) begin
          regs_write_en   <= (rd != 5'd0);
          regs_write_addr <= rd;
          regs_write_data <= ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single transactions plus
// hand-written sequences for timeout, reset mid-load and request priority.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_load_mode;
  logic [31:0] mem_load_addr;
  logic [4:0]  mem_load_regs_addr;
  logic [1:0]  mem_store_mode;
  logic [31:0] mem_store_addr;
  logic [31:0] mem_store_data;
  logic        busy, regs_write_en, unpause_signal, error, bus_req, bus_we;
  logic [4:0]  regs_write_addr;
  logic [31:0] regs_write_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.XLEN(32), .TIMEOUT(255)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_load_mode      (mem_load_mode),
    .mem_load_addr      (mem_load_addr),
    .mem_load_regs_addr (mem_load_regs_addr),
    .mem_store_mode     (mem_store_mode),
    .mem_store_addr     (mem_store_addr),
    .mem_store_data     (mem_store_data),
    .busy               (busy),
    .regs_write_en      (regs_write_en),
    .regs_write_addr    (regs_write_addr),
    .regs_write_data    (regs_write_data),
    .unpause_signal     (unpause_signal),
    .error              (error),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_wstrb          (bus_wstrb),
    .bus_gnt            (bus_gnt),
    .bus_rvalid         (bus_rvalid),
    .bus_rdata          (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  lmode;
    logic [1:0]  smode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_wb;
    logic [31:0] exp_wb_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_load_mode      = 3'b111;
    mem_load_addr      = '0;
    mem_load_regs_addr = '0;
    mem_store_mode     = 2'b00;
    mem_store_addr     = '0;
    mem_store_data     = '0;
  endtask

  task automatic run(input vec_t v, input string tag);
    logic ld;
    ld = (v.lmode != 3'b111);
    @(negedge clk);
    mem_load_mode      = v.lmode;
    mem_load_addr      = v.addr;
    mem_load_regs_addr = v.rd;
    mem_store_mode     = v.smode;
    mem_store_addr     = v.addr;
    mem_store_data     = v.data;
    @(negedge clk);
    idle_inputs();
    if (v.exp_err) begin
      chk1({tag, " err"}, error, 1'b1);
      chk1({tag, " err unpause"}, unpause_signal, 1'b1);
      chk1({tag, " err req"}, bus_req, 1'b0);
      chk1({tag, " err busy"}, busy, 1'b0);
      @(negedge clk);
      chk1({tag, " err pulse"}, error, 1'b0);
      chk1({tag, " err req2"}, bus_req, 1'b0);
      return;
    end
    chk1({tag, " req"}, bus_req, 1'b1);
    chk1({tag, " busy"}, busy, 1'b1);
    chk1({tag, " we"}, bus_we, !ld);
    chk({tag, " addr"}, bus_addr, v.exp_addr);
    if (!ld) begin
      chk({tag, " wstrb"}, {28'b0, bus_wstrb}, {28'b0, v.exp_wstrb});
      chk({tag, " wdata"}, bus_wdata, v.exp_wdata);
    end
    repeat (v.gnt_dly) begin
      @(negedge clk);
      chk1({tag, " req hold"}, bus_req, 1'b1);
      chk({tag, " addr hold"}, bus_addr, v.exp_addr);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1({tag, " req drop"}, bus_req, 1'b0);
    if (!ld) begin
      chk1({tag, " done no unpause yet"}, unpause_signal, 1'b0);
      @(negedge clk);
      chk1({tag, " st unpause"}, unpause_signal, 1'b1);
      chk1({tag, " st no wb"}, regs_write_en, 1'b0);
      chk1({tag, " st idle"}, busy, 1'b0);
    end else begin
      repeat (v.rv_dly) @(negedge clk);
      bus_rvalid = 1'b1;
      bus_rdata  = v.rdata;
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      chk1({tag, " done busy"}, busy, 1'b1);
      chk1({tag, " done no wb yet"}, regs_write_en, 1'b0);
      @(negedge clk);
      chk1({tag, " ld unpause"}, unpause_signal, 1'b1);
      chk1({tag, " wb en"}, regs_write_en, v.exp_wb);
      if (v.exp_wb) begin
        chk({tag, " wb addr"}, {27'b0, regs_write_addr}, {27'b0, v.rd});
        chk({tag, " wb data"}, regs_write_data, v.exp_wb_data);
      end
    end
    @(negedge clk);
    chk1({tag, " unpause pulse"}, unpause_signal, 1'b0);
    chk1({tag, " wb pulse"}, regs_write_en, 1'b0);
  endtask

  vec_t vt[14];
  vec_t v;
  int   n;

  initial begin
    //           lmode   smode  addr          data          rd    g  r  rdata         err   exp_addr      wstrb  wdata         wb    wb_data
    vt[0]  = '{3'b111, 2'b11, 32'h100, 32'hDEADBEEF, 5'd0,  2, 0, 32'h0,        1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{3'b111, 2'b01, 32'h103, 32'h000000A5, 5'd0,  0, 0, 32'h0,        1'b0, 32'h100, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0};
    vt[2]  = '{3'b111, 2'b10, 32'h202, 32'h1234BEEF, 5'd0,  1, 0, 32'h0,        1'b0, 32'h200, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0};
    vt[3]  = '{3'b111, 2'b01, 32'h201, 32'hFFFFFF3C, 5'd0,  0, 0, 32'h0,        1'b0, 32'h200, 4'b0010, 32'h3C3C3C3C, 1'b0, 32'h0};
    vt[4]  = '{3'b000, 2'b00, 32'h102, 32'h0,        5'd5,  0, 0, 32'h0080FF00, 1'b0, 32'h100, 4'b0000, 32'h0,        1'b1, 32'hFFFFFF80};
    vt[5]  = '{3'b100, 2'b00, 32'h102, 32'h0,        5'd5,  0, 0, 32'h0080FF00, 1'b0, 32'h100, 4'b0000, 32'h0,        1'b1, 32'h00000080};
    vt[6]  = '{3'b001, 2'b00, 32'h102, 32'h0,        5'd9,  1, 1, 32'h80017FFF, 1'b0, 32'h100, 4'b0000, 32'h0,        1'b1, 32'hFFFF8001};
    vt[7]  = '{3'b101, 2'b00, 32'h100, 32'h0,        5'd10, 0, 0, 32'h1234F00D, 1'b0, 32'h100, 4'b0000, 32'h0,        1'b1, 32'h0000F00D};
    vt[8]  = '{3'b010, 2'b00, 32'h104, 32'h0,        5'd31, 3, 2, 32'hCAFEBABE, 1'b0, 32'h104, 4'b0000, 32'h0,        1'b1, 32'hCAFEBABE};
    vt[9]  = '{3'b000, 2'b00, 32'h101, 32'h0,        5'd0,  0, 0, 32'h00007F00, 1'b0, 32'h100, 4'b0000, 32'h0,        1'b0, 32'h0};
    vt[10] = '{3'b010, 2'b00, 32'h102, 32'h0,        5'd4,  0, 0, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};
    vt[11] = '{3'b111, 2'b10, 32'h101, 32'h0,        5'd0,  0, 0, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};
    vt[12] = '{3'b111, 2'b11, 32'h102, 32'h0,        5'd0,  0, 0, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};
    vt[13] = '{3'b001, 2'b00, 32'h103, 32'h0,        5'd6,  0, 0, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0};

    rst        = 1'b1;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk1("rst busy", busy, 1'b0);
    chk1("rst req", bus_req, 1'b0);
    chk1("rst wb", regs_write_en, 1'b0);
    chk1("rst unpause", unpause_signal, 1'b0);
    chk1("rst error", error, 1'b0);
    chk("rst addr", bus_addr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run(vt[i], $sformatf("vec%0d", i));

    // Timeout: rvalid withheld after the grant
    @(negedge clk);
    mem_load_mode = 3'b010; mem_load_addr = 32'h10; mem_load_regs_addr = 5'd7;
    @(negedge clk);
    idle_inputs();
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    n = 0;
    while (!error && n < 400) begin
      chk1("to wait no wb", regs_write_en, 1'b0);
      @(negedge clk);
      n++;
    end
    chk1("to error", error, 1'b1);
    n_cmp++;
    if (n < 254 || n > 256) begin
      n_bad++;
      $display("FAIL to cycles: got %0d required 254..256", n);
    end
    chk1("to unpause", unpause_signal, 1'b1);
    chk1("to no wb", regs_write_en, 1'b0);
    chk1("to busy", busy, 1'b0);
    chk1("to req", bus_req, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    @(negedge clk);
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk1("to late rvalid wb", regs_write_en, 1'b0);
    chk1("to late rvalid busy", busy, 1'b0);
    run(vt[0], "after_to");

    // Reset while waiting for read data
    @(negedge clk);
    mem_load_mode = 3'b010; mem_load_addr = 32'h20; mem_load_regs_addr = 5'd8;
    @(negedge clk);
    idle_inputs();
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1("rw busy before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h22222222;
    chk1("rw req", bus_req, 1'b0);
    chk1("rw busy", busy, 1'b0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk1("rw no wb", regs_write_en, 1'b0);
    @(negedge clk);
    chk1("rw no wb2", regs_write_en, 1'b0);
    chk1("rw no unpause", unpause_signal, 1'b0);

    // Load and store together: load wins; rvalid during REQ is ignored
    @(negedge clk);
    mem_load_mode = 3'b010; mem_load_addr = 32'h300; mem_load_regs_addr = 5'd3;
    mem_store_mode = 2'b11; mem_store_addr = 32'h400; mem_store_data = 32'h55555555;
    @(negedge clk);
    idle_inputs();
    chk1("both we", bus_we, 1'b0);
    chk("both addr", bus_addr, 32'h300);
    bus_rvalid = 1'b1; bus_rdata = 32'hBADBAD00;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk1("both req held", bus_req, 1'b1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk1("both wb en", regs_write_en, 1'b1);
    chk("both wb addr", {27'b0, regs_write_addr}, 32'd3);
    chk("both wb data", regs_write_data, 32'h0BADF00D);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the data-memory bus. It accepts at most one load or store per transaction from the execute stage, performs it over a simple request/grant/read-valid bus, aligns and sign-extends load data, and returns the loaded value to the register file. While a transaction is in flight it holds the pipeline paused. When it finishes it raises `unpause_signal` for one cycle.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `TIMEOUT`, 255: maximum number of cycles spent waiting for `bus_gnt` or `bus_rvalid` before the transaction is aborted.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `mem_load_mode`  in  3  load type, as the RV32I load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU); 111 means no load.
- `mem_load_addr`  in  XLEN  load byte address.
- `mem_load_regs_addr`  in  5  destination register for the load.
- `mem_store_mode`  in  2  store type: 00 none, 01 SB, 10 SH, 11 SW.
- `mem_store_addr`  in  XLEN  store byte address.
- `mem_store_data`  in  XLEN  store data, right-justified.
- `busy`  out  1  a transaction is in flight; the pipeline must hold.
- `regs_write_en`, `regs_write_addr[4:0]`, `regs_write_data[XLEN]`  out  load writeback to the register file.
- `unpause_signal`  out  1  one-cycle pulse when a transaction completes or aborts.
- `error`  out  1  one-cycle pulse on a misaligned access or a timeout.
- `bus_req`, `bus_we`  out  1  bus request and write enable.
- `bus_addr`  out  XLEN  word-aligned address (bits [1:0] are always 0).
- `bus_wdata`  out  XLEN  lane-shifted write data.
- `bus_wstrb`  out  4  byte enables.
- `bus_gnt`, `bus_rvalid`  in  1  bus grant and read-data valid.
- `bus_rdata`  in  XLEN  read data, one full word.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE. In reset every output is 0 and the state is IDLE.
- **IDLE:** a load is requested when `mem_load_mode != 111`; a store is requested when `mem_store_mode != 00`. If both are requested, the load wins and the store is dropped. The unit latches the mode, address, data and rd, then checks alignment:
  - Misaligned means a halfword with `addr[0]=1`, or a word with `addr[1:0]!=0`.
  - On a misaligned access: pulse `error` and `unpause_signal`, make no bus access, stay in IDLE.
  - Otherwise go to REQ.
- **REQ:** hold `bus_req=1` with stable `bus_addr`, `bus_we`, `bus_wdata` and `bus_wstrb` until `bus_gnt=1`.
  - A store completes on the grant and goes to DONE.
  - A load goes to WAIT on the grant.
- **WAIT:** on `bus_rvalid`, register the extracted load data and go to DONE. `bus_rvalid` is never sampled in the grant cycle.
- **DONE:** for one cycle, pulse `unpause_signal`. For loads, also assert `regs_write_en`, except when rd=0. Then go to IDLE.
- **Store lanes**, using byte offset `off = addr[1:0]`:
  - SB: `wstrb = 0001 << off`, data byte replicated on all lanes.
  - SH: `wstrb = 0011 << off`, halfword replicated.
  - SW: `wstrb = 1111`.
- **Load extraction:** select the byte or halfword at `off`; LB and LH sign-extend, LBU and LHU zero-extend.
- **Timeout:** a counter resets on entry to REQ and WAIT. When it reaches `TIMEOUT`, drop `bus_req`, pulse `error` and `unpause_signal`, write nothing, and return to IDLE.
- `bus_rvalid` arriving in IDLE, REQ or DONE is ignored.
- **Reset mid-transaction:** go to IDLE on the next edge, with `bus_req` low from that edge onward. A late `bus_rvalid` is ignored and no writeback occurs.

## Timing
- `busy` is 1 in REQ, WAIT and DONE, and is registered.
- Minimum store latency is 3 cycles: request in IDLE at edge 0, REQ with grant at edge 1, DONE at edge 2, unpause visible after edge 2.
- Minimum load latency is 4 cycles: IDLE, REQ with grant, WAIT with rvalid, DONE with writeback.
- Every bus output is driven from a register. Writeback and unpause outputs are registered and last exactly one cycle.

## Structure
- The shared constants package holds:
  - load-mode codes, including NONE=111;
  - store-mode codes, including NONE=00;
  - the FSM state encoding.
- One combinational sub-module, `lsu_align`, does store lane shifting and strobe generation and load byte selection with extension. The FSM and counter stay in `lsu`.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, grant after 2 cycles -> `wstrb=1111`, `wdata=0xDEADBEEF`, unpause 1 cycle after grant, no writeback.
- SB to 0x103 with data 0x000000A5 -> `bus_addr=0x100`, `wstrb=1000`, `wdata=0xA5A5A5A5`.
- LB from 0x102, rdata 0x0080FF00, rd=5 -> `regs_write_data=0xFFFFFF80` written to x5; the same access as LBU writes 0x00000080.
- LW from 0x102 -> `error` and unpause pulse, `bus_req` never asserted.
- Load with rvalid withheld for 255 cycles -> `error`, no writeback, back in IDLE; the next SW completes normally.
- `rst` asserted in WAIT followed by rvalid -> `bus_req` 0, no writeback, `busy` 0 after reset.
